// File: rtl/mc_pkg.sv
// mc_pkg: shared types and encodings for the multi-cycle control sequencer.
//   state_t   - FSM states (FETCH, DECODE, EXEC, MEM, WB)
//   iclass_t  - decoded instruction class
//   OP_*/FN_* - opcode and R-type funct encodings
//   ALU_*, NPC_*, RD_* - alu_op, npc_sel and regdst codes driven to the datapath
`timescale 1ns/1ps
package mc_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    CL_NOP     = 4'd0,
    CL_ADDU    = 4'd1,
    CL_SUBU    = 4'd2,
    CL_JR      = 4'd3,
    CL_ORI     = 4'd4,
    CL_LUI     = 4'd5,
    CL_LW      = 4'd6,
    CL_SW      = 4'd7,
    CL_BEQ     = 4'd8,
    CL_J       = 4'd9,
    CL_JAL     = 4'd10,
    CL_ILLEGAL = 4'd11
  } iclass_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_NOP   = 6'b000000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [1:0] ALU_ADD  = 2'd0;
  localparam logic [1:0] ALU_SUB  = 2'd1;
  localparam logic [1:0] ALU_OR   = 2'd2;
  localparam logic [1:0] ALU_LUI  = 2'd3;

  localparam logic [1:0] NPC_PC4  = 2'd0;
  localparam logic [1:0] NPC_BR   = 2'd1;
  localparam logic [1:0] NPC_JMP  = 2'd2;
  localparam logic [1:0] NPC_REG  = 2'd3;

  localparam logic [1:0] RD_RT    = 2'd0;
  localparam logic [1:0] RD_RD    = 2'd1;
  localparam logic [1:0] RD_RA    = 2'd2;

  // Classes whose path passes through EXEC after DECODE.
  function automatic logic needs_exec(input iclass_t c);
    case (c)
      CL_ADDU, CL_SUBU, CL_ORI, CL_LUI,
      CL_LW, CL_SW, CL_BEQ, CL_JR: needs_exec = 1'b1;
      default:                     needs_exec = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_decode.sv
// mc_decode: purely combinational instruction classifier.
//   opcode - IR[31:26]
//   funct  - IR[5:0], only meaningful for opcode 000000
//   iclass - decoded class; any unsupported encoding maps to CL_ILLEGAL
`timescale 1ns/1ps
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output iclass_t    iclass
);

  always_comb begin
    iclass = CL_ILLEGAL;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: iclass = CL_ADDU;
          FN_SUBU: iclass = CL_SUBU;
          FN_JR:   iclass = CL_JR;
          FN_NOP:  iclass = CL_NOP;
          default: iclass = CL_ILLEGAL;
        endcase
      end
      OP_ORI:  iclass = CL_ORI;
      OP_LUI:  iclass = CL_LUI;
      OP_LW:   iclass = CL_LW;
      OP_SW:   iclass = CL_SW;
      OP_BEQ:  iclass = CL_BEQ;
      OP_J:    iclass = CL_J;
      OP_JAL:  iclass = CL_JAL;
      default: iclass = CL_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the
// MIPS-subset datapath, plus a retired-instruction counter.
//   clk, reset      - rising-edge clock, asynchronous active-low reset
//   opcode, funct   - IR fields, stable from end of FETCH to next FETCH
//   zero            - ALU equal flag, used by BEQ in EXEC
//   pc_we, ir_we, mem_we, reg_we - datapath write enables
//   memtoreg, jal, regdst        - register write data / address selects
//   alusrc, ext_sign, alu_op     - ALU operand and operation controls
//   npc_sel         - next-PC source
//   illegal         - one-cycle pulse in DECODE for unsupported encodings
//   instr_cnt       - count of instructions returned to FETCH (wraps)
`timescale 1ns/1ps
module mc_controller
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             pc_we,
  output logic             ir_we,
  output logic             mem_we,
  output logic             reg_we,
  output logic             memtoreg,
  output logic             jal,
  output logic [1:0]       regdst,
  output logic             alusrc,
  output logic             ext_sign,
  output logic [1:0]       alu_op,
  output logic [1:0]       npc_sel,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_cnt
);

  state_t            state_reg, state_next;
  iclass_t           class_reg;
  iclass_t           dec_class;
  logic              active_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              retire;

  mc_decode u_decode (
    .opcode (opcode),
    .funct  (funct),
    .iclass (dec_class)
  );

  // active_reg holds the sequencer idle for the first cycle after reset
  // release, so the first FETCH enables show up one cycle later and the
  // FETCH state is not consumed by that release edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= ST_FETCH;
      class_reg  <= CL_NOP;
      active_reg <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      active_reg <= 1'b1;
      state_reg  <= state_next;
      if (active_reg && state_reg == ST_DECODE)
        class_reg <= dec_class;
      if (retire)
        cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  // Next state. DECODE branches on the live decode; later states use the
  // class captured at the end of DECODE.
  always_comb begin
    state_next = state_reg;
    if (active_reg) begin
      case (state_reg)
        ST_FETCH:  state_next = ST_DECODE;
        ST_DECODE: begin
          if (needs_exec(dec_class))
            state_next = ST_EXEC;
          else if (dec_class == CL_JAL)
            state_next = ST_WB;
          else
            state_next = ST_FETCH;
        end
        ST_EXEC: begin
          case (class_reg)
            CL_LW, CL_SW:  state_next = ST_MEM;
            CL_BEQ, CL_JR: state_next = ST_FETCH;
            default:       state_next = ST_WB;
          endcase
        end
        ST_MEM:  state_next = (class_reg == CL_LW) ? ST_WB : ST_FETCH;
        ST_WB:   state_next = ST_FETCH;
        default: state_next = ST_FETCH;
      endcase
    end
  end

  // An instruction retires whenever the FSM leaves a non-FETCH state for FETCH.
  assign retire    = active_reg && (state_reg != ST_FETCH) && (state_next == ST_FETCH);
  assign instr_cnt = cnt_reg;

  // Output decode. Gated by the reset pin itself so an asserted reset kills
  // every enable in the same cycle, before the async clear propagates.
  always_comb begin
    pc_we    = 1'b0;
    ir_we    = 1'b0;
    mem_we   = 1'b0;
    reg_we   = 1'b0;
    memtoreg = 1'b0;
    jal      = 1'b0;
    regdst   = RD_RT;
    alusrc   = 1'b0;
    ext_sign = 1'b0;
    alu_op   = ALU_ADD;
    npc_sel  = NPC_PC4;
    illegal  = 1'b0;
    if (reset && active_reg) begin
      case (state_reg)
        ST_FETCH: begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          npc_sel = NPC_PC4;
        end
        ST_DECODE: begin
          if (dec_class == CL_J) begin
            pc_we   = 1'b1;
            npc_sel = NPC_JMP;
          end
          if (dec_class == CL_ILLEGAL)
            illegal = 1'b1;
        end
        ST_EXEC: begin
          case (class_reg)
            CL_ADDU: alu_op = ALU_ADD;
            CL_SUBU: alu_op = ALU_SUB;
            CL_ORI: begin
              alu_op   = ALU_OR;
              alusrc   = 1'b1;
              ext_sign = 1'b0;
            end
            CL_LUI: begin
              alu_op = ALU_LUI;
              alusrc = 1'b1;
            end
            CL_LW, CL_SW: begin
              alu_op   = ALU_ADD;
              alusrc   = 1'b1;
              ext_sign = 1'b1;
            end
            CL_BEQ: begin
              alu_op  = ALU_SUB;
              pc_we   = zero;
              npc_sel = NPC_BR;
            end
            CL_JR: begin
              pc_we   = 1'b1;
              npc_sel = NPC_REG;
            end
            default: ;
          endcase
        end
        ST_MEM: mem_we = (class_reg == CL_SW);
        ST_WB: begin
          reg_we = 1'b1;
          case (class_reg)
            CL_ADDU, CL_SUBU: regdst = RD_RD;
            CL_LW: begin
              regdst   = RD_RT;
              memtoreg = 1'b1;
            end
            CL_JAL: begin
              regdst  = RD_RA;
              jal     = 1'b1;
              pc_we   = 1'b1;
              npc_sel = NPC_JMP;
            end
            default: regdst = RD_RT;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed plus randomized instruction stream against a
// table-level reference model (class name -> state path -> expected outputs).
`timescale 1ns/1ps
module tb_mc_controller;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [5:0]       opcode, funct;
  logic             zero;
  logic             pc_we, ir_we, mem_we, reg_we, memtoreg, jal;
  logic [1:0]       regdst, alu_op, npc_sel;
  logic             alusrc, ext_sign, illegal;
  logic [CNT_W-1:0] instr_cnt;

  int checks = 0;
  int errors = 0;
  int model_cnt = 0;
  int n_instr = 0;

  always #5 clk = ~clk;

  mc_controller #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .funct     (funct),
    .zero      (zero),
    .pc_we     (pc_we),
    .ir_we     (ir_we),
    .mem_we    (mem_we),
    .reg_we    (reg_we),
    .memtoreg  (memtoreg),
    .jal       (jal),
    .regdst    (regdst),
    .alusrc    (alusrc),
    .ext_sign  (ext_sign),
    .alu_op    (alu_op),
    .npc_sel   (npc_sel),
    .illegal   (illegal),
    .instr_cnt (instr_cnt)
  );

  wire [14:0] ctrl = {pc_we, ir_we, mem_we, reg_we, memtoreg, jal, regdst,
                      alusrc, ext_sign, alu_op, npc_sel, illegal};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic string cls_of(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'b000000) begin
      if (fn == 6'b100001) return "ADDU";
      if (fn == 6'b100011) return "SUBU";
      if (fn == 6'b001000) return "JR";
      if (fn == 6'b000000) return "NOP";
      return "ILL";
    end
    if (op == 6'b001101) return "ORI";
    if (op == 6'b001111) return "LUI";
    if (op == 6'b100011) return "LW";
    if (op == 6'b101011) return "SW";
    if (op == 6'b000100) return "BEQ";
    if (op == 6'b000010) return "J";
    if (op == 6'b000011) return "JAL";
    return "ILL";
  endfunction

  function automatic string path_of(input string c);
    if (c == "ADDU" || c == "SUBU" || c == "ORI" || c == "LUI") return "FDEW";
    if (c == "LW")  return "FDEMW";
    if (c == "SW")  return "FDEM";
    if (c == "BEQ" || c == "JR") return "FDE";
    if (c == "JAL") return "FDW";
    return "FD";
  endfunction

  // Expected {pc_we,ir_we,mem_we,reg_we,memtoreg,jal,regdst,alusrc,ext_sign,alu_op,npc_sel,illegal}
  function automatic logic [14:0] exp_ctrl(input string c, input byte st, input bit z);
    bit pc = 0, ir = 0, mw = 0, rw = 0, m2r = 0, jl = 0, asrc = 0, ext = 0, ill = 0;
    bit [1:0] rd = 0, aop = 0, npc = 0;
    if (st == "F") begin
      pc = 1; ir = 1;
    end else if (st == "D") begin
      if (c == "J")   begin pc = 1; npc = 2; end
      if (c == "ILL") ill = 1;
    end else if (st == "E") begin
      if (c == "SUBU" || c == "BEQ") aop = 1;
      if (c == "ORI") begin aop = 2; asrc = 1; end
      if (c == "LUI") begin aop = 3; asrc = 1; end
      if (c == "LW" || c == "SW") begin asrc = 1; ext = 1; end
      if (c == "BEQ") begin pc = z; npc = 1; end
      if (c == "JR")  begin pc = 1; npc = 3; end
    end else if (st == "M") begin
      if (c == "SW") mw = 1;
    end else if (st == "W") begin
      rw = 1;
      if (c == "ADDU" || c == "SUBU") rd = 1;
      if (c == "LW")  m2r = 1;
      if (c == "JAL") begin rd = 2; jl = 1; pc = 1; npc = 2; end
    end
    return {pc, ir, mw, rw, m2r, jl, rd, asrc, ext, aop, npc, ill};
  endfunction

  // Entered at posedge+1 with the DUT in FETCH. abort_k >= 0 asserts reset
  // during that state of the path instead of finishing the instruction.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input bit z, input int abort_k);
    string c, p;
    c = cls_of(op, fn);
    p = path_of(c);
    opcode = op; funct = fn; zero = z;
    $display("instr %0d: op=%b fn=%b zero=%0d class=%s path=%s cnt_exp=%0d",
             n_instr, op, fn, z, c, p, model_cnt);
    n_instr++;
    for (int k = 0; k < p.len(); k++) begin
      #1;
      check_eq($sformatf("%s.%c.ctrl", c, p[k]), 32'(ctrl), 32'(exp_ctrl(c, p[k], z)));
      if (k == 0) check_eq($sformatf("%s.cnt", c), 32'(instr_cnt), 32'(model_cnt));
      if (k == abort_k) begin
        reset = 1'b0;
        #1;
        check_eq("rst_ctrl", 32'(ctrl), 32'd0);
        check_eq("rst_cnt", 32'(instr_cnt), 32'd0);
        model_cnt = 0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check_eq("rel_ctrl", 32'(ctrl), 32'd0);
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    model_cnt = (model_cnt + 1) % (1 << CNT_W);
  endtask

  logic [5:0] rop, rfn;

  initial begin
    reset = 1'b0; opcode = 6'd0; funct = 6'd0; zero = 1'b0;
    #2;
    check_eq("reset_ctrl", 32'(ctrl), 32'd0);
    check_eq("reset_cnt", 32'(instr_cnt), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1 check_eq("release_ctrl", 32'(ctrl), 32'd0);
    @(posedge clk); #1;

    // Directed sequence.
    run_instr(6'b100011, 6'd0, 1'b0, -1);        // LW
    run_instr(6'b000011, 6'd0, 1'b0, -1);        // JAL
    run_instr(6'b000100, 6'd0, 1'b1, -1);        // BEQ taken
    run_instr(6'b000100, 6'd0, 1'b0, -1);        // BEQ not taken
    run_instr(6'b111111, 6'd0, 1'b0, -1);        // illegal opcode
    run_instr(6'b000000, 6'b101010, 1'b0, -1);   // illegal funct
    run_instr(6'b000010, 6'd0, 1'b0, -1);        // J
    run_instr(6'b000000, 6'b001000, 1'b0, -1);   // JR
    run_instr(6'b101011, 6'd0, 1'b0, 3);         // SW, reset in MEM
    for (int i = 0; i < 16; i++)
      run_instr(6'b000000, 6'b000000, 1'b0, -1); // NOPs, counter wraps
    check_eq("wrap_cnt", 32'(instr_cnt), 32'd0);

    // Randomized stream.
    for (int i = 0; i < 300; i++) begin
      rfn = 6'($urandom);
      case ($urandom_range(0, 12))
        0:  begin rop = 6'b000000; rfn = 6'b100001; end
        1:  begin rop = 6'b000000; rfn = 6'b100011; end
        2:  begin rop = 6'b000000; rfn = 6'b001000; end
        3:  begin rop = 6'b000000; rfn = 6'b000000; end
        4:  rop = 6'b001101;
        5:  rop = 6'b001111;
        6:  rop = 6'b100011;
        7:  rop = 6'b101011;
        8:  rop = 6'b000100;
        9:  rop = 6'b000010;
        10: rop = 6'b000011;
        11: rop = 6'b000000;
        default: rop = 6'($urandom);
      endcase
      run_instr(rop, rfn, 1'($urandom), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
